dpram_port_arbiter: RTL and testbench

Shares one dual_port_ram (two read/write ports) between N requesters, each with its own valid/ready request channel. Each cycle the block grants up to two requests in round-robin order and steers them onto RAM port 1 and port 2. It serialises same-address conflicts between the two ports. Read data returns to the owning requester one cycle after the grant, tagged by a per-requester response valid.

---
 rtl/dpram_port_arbiter_pkg.sv | 20 ++
 rtl/dpram_port_arbiter_rr_pick.sv | 35 +++
 rtl/dpram_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_dpram_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_port_arbiter_pkg.sv
// Shared defaults and encodings for the dual-port RAM arbiter.
package dpram_port_arbiter_pkg;

   localparam int AW_DEF = 6;
   localparam int DW_DEF = 8;

   // Which RAM port, if any, a requester owns in the current cycle.
   typedef enum logic [1:0] {
      PORT_NONE = 2'd0,
      PORT_1    = 2'd1,
      PORT_2    = 2'd2
   } port_sel_e;

   // Two accesses may not share a cycle if they hit the same word and either one writes.
   function automatic logic accesses_conflict(input logic we_a, input logic we_b,
                                              input logic adr_eq);
      return adr_eq && (we_a || we_b);
   endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after ptr (wrapping) that is both
// valid and eligible.
module rr_pick
   import dpram_port_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [N-1:0]  elig,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] idx,
   output logic          found
);

   int            cand;
   logic [PW-1:0] cand_idx;

   // Scan from ptr and latch the first hit.
   always_comb begin
      idx      = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 0; k < N; k++) begin
         cand     = (int'(ptr) + k) % N;
         cand_idx = PW'(cand);
         if (!found && valid[cand_idx] && elig[cand_idx]) begin
            found = 1'b1;
            idx   = cand_idx;
         end
      end
   end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares one dual-port RAM between N valid/ready requesters: up to two grants
// per cycle in round-robin order, with same-address write conflicts pushed to
// a later cycle. Read data is routed back to its owner one cycle after grant.
module dpram_port_arbiter
   import dpram_port_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]    req_valid,
   input  logic [N-1:0]    req_we,
   input  logic [N*AW-1:0] req_adr,
   input  logic [N*DW-1:0] req_data,
   output logic [N-1:0]    req_ready,
   output logic [N-1:0]    rsp_valid,
   output logic [N*DW-1:0] rsp_data,
   output logic [DW-1:0]   ram_data1,
   output logic [DW-1:0]   ram_data2,
   output logic [AW-1:0]   ram_adr1,
   output logic [AW-1:0]   ram_adr2,
   output logic          ram_we1,
   output logic          ram_we2,
   input  logic [DW-1:0]   ram_q1,
   input  logic [DW-1:0]   ram_q2
);

   localparam int PW = $clog2(N);

   logic [PW-1:0] ptr, ptr_nxt;
   logic [PW-1:0] idx1, idx2;
   logic          found1, found2;
   logic [N-1:0]  elig2;
   logic [AW-1:0] adr_w1;
   logic          we_w1;
   port_sel_e     sel [N];

   logic          rd1_q, rd2_q;
   logic [PW-1:0] own1_q, own2_q;
   logic [N*DW-1:0] rsp_hold;

   rr_pick #(.N(N), .PW(PW)) u_pick1 (
      .valid (req_valid),
      .elig  ({N{1'b1}}),
      .ptr   (ptr),
      .idx   (idx1),
      .found (found1)
   );

   rr_pick #(.N(N), .PW(PW)) u_pick2 (
      .valid (req_valid),
      .elig  (elig2),
      .ptr   (ptr),
      .idx   (idx2),
      .found (found2)
   );

   // Port 2 candidates: anyone but the port 1 winner that does not collide with it.
   always_comb begin
      adr_w1 = req_adr[int'(idx1)*AW +: AW];
      we_w1  = req_we[idx1];
      elig2  = '0;
      for (int i = 0; i < N; i++) begin
         elig2[i] = found1 && (PW'(i) != idx1) &&
                    !accesses_conflict(req_we[i], we_w1, req_adr[i*AW +: AW] == adr_w1);
      end
   end

   // Grant steering onto the two RAM ports; everything is held off while in reset.
   always_comb begin
      req_ready = '0;
      ram_adr1  = '0;
      ram_data1 = '0;
      ram_we1   = 1'b0;
      ram_adr2  = '0;
      ram_data2 = '0;
      ram_we2   = 1'b0;
      for (int i = 0; i < N; i++) begin
         sel[i] = PORT_NONE;
         if (!rst && found1 && idx1 == PW'(i))
            sel[i] = PORT_1;
         else if (!rst && found2 && idx2 == PW'(i))
            sel[i] = PORT_2;
         req_ready[i] = (sel[i] != PORT_NONE);
      end
      if (found1) begin
         ram_adr1  = adr_w1;
         ram_data1 = req_data[int'(idx1)*DW +: DW];
         ram_we1   = we_w1 && !rst;
      end
      if (found2) begin
         ram_adr2  = req_adr[int'(idx2)*AW +: AW];
         ram_data2 = req_data[int'(idx2)*DW +: DW];
         ram_we2   = req_we[idx2] && !rst;
      end
   end

   // Next scan start: one past the last winner in scan order (port 2 trails port 1).
   always_comb begin
      ptr_nxt = ptr;
      if (found2)
         ptr_nxt = (idx2 == PW'(N-1)) ? '0 : idx2 + 1'b1;
      else if (found1)
         ptr_nxt = (idx1 == PW'(N-1)) ? '0 : idx1 + 1'b1;
   end

   // Pointer, per-port owner/read flags and the held response data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr      <= '0;
         rd1_q    <= 1'b0;
         rd2_q    <= 1'b0;
         own1_q   <= '0;
         own2_q   <= '0;
         rsp_hold <= '0;
      end else begin
         ptr      <= ptr_nxt;
         rd1_q    <= found1 && !req_we[idx1];
         rd2_q    <= found2 && !req_we[idx2];
         own1_q   <= idx1;
         own2_q   <= idx2;
         rsp_hold <= rsp_data;
      end
   end

   // RAM q is valid the cycle after grant, so responses pass straight through to owners.
   always_comb begin
      rsp_valid = '0;
      rsp_data  = rsp_hold;
      if (rd1_q) begin
         rsp_valid[own1_q]                 = 1'b1;
         rsp_data[int'(own1_q)*DW +: DW] = ram_q1;
      end
      if (rd2_q) begin
         rsp_valid[own2_q]                 = 1'b1;
         rsp_data[int'(own2_q)*DW +: DW] = ram_q2;
      end
   end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural dual-port RAM.
module tb_dpram_port_arbiter;

   localparam int N  = 4;
   localparam int AW = 6;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
   logic [N*AW-1:0] req_adr;
   logic [N*DW-1:0] req_data, rsp_data;
   logic [DW-1:0]   ram_data1, ram_data2, ram_q1, ram_q2;
   logic [AW-1:0]   ram_adr1, ram_adr2;
   logic          ram_we1, ram_we2;

   int vecs = 0;
   int errs = 0;
   int cnt [N];
   logic [N-1:0] exp_rdy, prev_rdy;

   logic          mem_init;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   dpram_port_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_adr   (req_adr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .ram_data1 (ram_data1),
      .ram_data2 (ram_data2),
      .ram_adr1  (ram_adr1),
      .ram_adr2  (ram_adr2),
      .ram_we1   (ram_we1),
      .ram_we2   (ram_we2),
      .ram_q1    (ram_q1),
      .ram_q2    (ram_q2)
   );

   always #5 clk = ~clk;

   // Registered-read RAM; contents start as 0x80 + address.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int a = 0; a < (1<<AW); a++) mem[a] <= 8'h80 + 8'(a);
      end else begin
         if (ram_we1) mem[ram_adr1] <= ram_data1;
         if (ram_we2) mem[ram_adr2] <= ram_data2;
      end
      ram_q1 <= mem[ram_adr1];
      ram_q2 <= mem[ram_adr2];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      req_valid = '0;
      req_we    = '0;
      req_adr   = '0;
      req_data  = '0;
   endtask

   task automatic put(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i]         = 1'b1;
      req_we[i]            = we;
      req_adr[i*AW +: AW]  = a;
      req_data[i*DW +: DW] = d;
   endtask

   function automatic logic [DW-1:0] rd(input int i);
      return rsp_data[i*DW +: DW];
   endfunction

   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < N; i++) cnt[i] = 0;
      mem_init = 1'b1;
      rst      = 1'b1;
      idle();
      put(0, 1'b1, 6'h01, 8'h33);
      to_drive();
      mem_init = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_we1", 32'(ram_we1), 0);
      chk("rst_we2", 32'(ram_we2), 0);
      chk("rst_ptr", 32'(dut.ptr), 0);
      rst = 1'b0;
      idle();
      to_drive();

      // two writes to distinct addresses in one cycle
      put(0, 1'b1, 6'h01, 8'h33);
      put(1, 1'b1, 6'h02, 8'h44);
      @(negedge clk);
      chk("t1_ready", 32'(req_ready), 4'b0011);
      chk("t1_we1", 32'(ram_we1), 1);
      chk("t1_we2", 32'(ram_we2), 1);
      chk("t1_adr1", 32'(ram_adr1), 8'h01);
      chk("t1_data1", 32'(ram_data1), 8'h33);
      chk("t1_adr2", 32'(ram_adr2), 8'h02);
      chk("t1_data2", 32'(ram_data2), 8'h44);
      to_drive();
      chk("t1_ptr", 32'(dut.ptr), 2);

      // read both back from the other requesters
      idle();
      put(2, 1'b0, 6'h01, 8'h00);
      put(3, 1'b0, 6'h02, 8'h00);
      @(negedge clk);
      chk("t2_ready", 32'(req_ready), 4'b1100);
      chk("t2_we", 32'({ram_we1, ram_we2}), 0);
      to_drive();
      chk("t2_ptr", 32'(dut.ptr), 0);

      // write/read conflict on 0x03: req1 must wait
      idle();
      put(0, 1'b1, 6'h03, 8'h55);
      put(1, 1'b0, 6'h03, 8'h00);
      @(negedge clk);
      chk("t2_rsp_valid", 32'(rsp_valid), 4'b1100);
      chk("t2_rsp2", 32'(rd(2)), 8'h33);
      chk("t2_rsp3", 32'(rd(3)), 8'h44);
      chk("t3_ready", 32'(req_ready), 4'b0001);
      to_drive();

      idle();
      put(1, 1'b0, 6'h03, 8'h00);
      put(3, 1'b0, 6'h02, 8'h00);
      @(negedge clk);
      chk("t3_rsp_none", 32'(rsp_valid), 0);
      chk("t3b_ready", 32'(req_ready), 4'b1010);
      to_drive();

      // all four read distinct addresses for 8 cycles
      idle();
      for (int i = 0; i < N; i++) put(i, 1'b0, 6'(8'h10 + i), 8'h00);
      prev_rdy = '0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         exp_rdy = (k % 2 == 0) ? 4'b0011 : 4'b1100;
         if (k == 0) begin
            chk("t3b_rsp_valid", 32'(rsp_valid), 4'b1010);
            chk("t3b_rsp1", 32'(rd(1)), 8'h55);
            chk("t3b_rsp3", 32'(rd(3)), 8'h44);
         end else begin
            chk("t4_rsp_valid", 32'(rsp_valid), 32'(prev_rdy));
            for (int i = 0; i < N; i++) begin
               if (rsp_valid[i]) begin
                  cnt[i]++;
                  chk("t4_rsp_data", 32'(rd(i)), 32'(8'h90 + i));
               end
            end
         end
         chk("t4_ready", 32'(req_ready), 32'(exp_rdy));
         prev_rdy = exp_rdy;
         to_drive();
      end
      idle();
      @(negedge clk);
      chk("t4_rsp_last", 32'(rsp_valid), 4'b1100);
      for (int i = 0; i < N; i++) begin
         if (rsp_valid[i]) begin
            cnt[i]++;
            chk("t4_rsp_data", 32'(rd(i)), 32'(8'h90 + i));
         end
      end
      for (int i = 0; i < N; i++) chk("t4_rsp_count", cnt[i], 4);
      to_drive();

      // reset between a read grant and its response
      put(0, 1'b0, 6'h10, 8'h00);
      @(negedge clk);
      chk("t5_ready", 32'(req_ready), 4'b0001);
      to_drive();
      rst = 1'b1;
      put(1, 1'b1, 6'h05, 8'hAA);
      #1;
      chk("t5_rsp_valid", 32'(rsp_valid), 0);
      chk("t5_we1", 32'(ram_we1), 0);
      chk("t5_we2", 32'(ram_we2), 0);
      chk("t5_ready_rst", 32'(req_ready), 0);
      chk("t5_ptr", 32'(dut.ptr), 0);
      to_drive();
      chk("t5_we1_hold", 32'(ram_we1), 0);
      @(negedge clk);
      rst = 1'b0;
      idle();
      to_drive();
      @(negedge clk);
      chk("t5_rsp_after", 32'(rsp_valid), 0);
      to_drive();

      // read-read on the same address
      put(0, 1'b0, 6'h02, 8'h00);
      put(2, 1'b0, 6'h02, 8'h00);
      @(negedge clk);
      chk("t6_ready", 32'(req_ready), 4'b0101);
      chk("t6_adr", 32'({ram_adr1, ram_adr2}), 32'({6'h02, 6'h02}));
      to_drive();
      idle();
      @(negedge clk);
      chk("t6_rsp_valid", 32'(rsp_valid), 4'b0101);
      chk("t6_rsp0", 32'(rd(0)), 8'h44);
      chk("t6_rsp2", 32'(rd(2)), 8'h44);
      to_drive();
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 0);
      chk("hold_data", 32'(rd(0)), 8'h44);
      to_drive();

      // conflicting requester skipped, later one takes port 2
      put(0, 1'b1, 6'h05, 8'h66);
      put(1, 1'b0, 6'h05, 8'h00);
      put(2, 1'b0, 6'h06, 8'h00);
      @(negedge clk);
      chk("t7_ready", 32'(req_ready), 4'b0101);
      chk("t7_we1", 32'(ram_we1), 1);
      chk("t7_adr2", 32'(ram_adr2), 8'h06);
      to_drive();
      idle();
      put(1, 1'b0, 6'h05, 8'h00);
      @(negedge clk);
      chk("t7_rsp_valid", 32'(rsp_valid), 4'b0100);
      chk("t7_rsp2", 32'(rd(2)), 8'h86);
      chk("t7b_ready", 32'(req_ready), 4'b0010);
      to_drive();
      idle();
      @(negedge clk);
      chk("t7b_rsp_valid", 32'(rsp_valid), 4'b0010);
      chk("t7b_rsp1", 32'(rd(1)), 8'h66);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
